// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and helpers for the UART TX arbiter
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam int TMO_W  = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        LOAD      = 3'd2,
        START     = 3'd3,
        WAIT_BUSY = 3'd4,
        WAIT_DONE = 3'd5,
        GAP       = 3'd6
    } state_t;

    // Counters stick at all-ones instead of wrapping back to zero
    function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
        return (v == {TMO_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority pick starting after last_grant
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] winner,
    output logic          found
);

    // Scan last_grant+1 .. last_grant+N (mod N); the first asserted request wins
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(last_grant) + k) % N]) begin
                found  = 1'b1;
                winner = IW'((int'(last_grant) + k) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sequencing one shared UART TX core
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N         = 4,
    parameter int GAP_TICKS = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    boud_in,
    input  logic [N-1:0]            req_valid,
    input  logic [BYTE_W*N-1:0]     req_data,
    input  logic [N-1:0]            req_last,
    output logic [N-1:0]            req_ready,
    output logic                    tx_start,
    output logic [BYTE_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic                    grant_valid,
    output logic [$clog2(N)-1:0]    grant_id,
    output logic                    tx_err
);

    localparam int IW = $clog2(N);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] GAP_LIM = TMO_W'(GAP_TICKS - 1);

    state_t             state_q, state_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;
    logic [IW-1:0]      last_grant_q, last_grant_d;
    logic               grant_valid_q, grant_valid_d;
    logic               lock_q, lock_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [TMO_W-1:0]   gap_q, gap_d;

    logic [IW-1:0]      arb_winner;
    logic               arb_found;
    logic               sel_valid;
    logic               sel_last;
    logic [BYTE_W-1:0]  sel_data;
    logic               gap_done;
    logic               tmo_hit;

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .winner     (arb_winner),
        .found      (arb_found)
    );

    // Mux out the owning requester's valid/last/byte
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_id_q == IW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // Gap ends on the GAP_TICKS-th baud tick, or immediately when no gap is configured
    always_comb begin
        gap_done = (GAP_TICKS == 0) || (boud_in && (gap_q >= GAP_LIM));
        tmo_hit  = (tmo_q >= TMO_LIM);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_id_q    <= '0;
            last_grant_q  <= IW'(N - 1);
            grant_valid_q <= 1'b0;
            lock_q        <= 1'b0;
            tx_data_q     <= '0;
            tmo_q         <= '0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            grant_valid_q <= grant_valid_d;
            lock_q        <= lock_d;
            tx_data_q     <= tx_data_d;
            tmo_q         <= tmo_d;
            gap_q         <= gap_d;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        grant_valid_d = grant_valid_q;
        lock_d        = lock_q;
        tx_data_d     = tx_data_q;
        tmo_d         = tmo_q;
        gap_d         = gap_q;
        case (state_q)
            IDLE: begin
                if (en && (|req_valid)) state_d = ARB;
            end
            ARB: begin
                tmo_d  = '0;
                lock_d = 1'b0;
                if (arb_found) begin
                    grant_id_d    = arb_winner;
                    last_grant_d  = arb_winner;
                    grant_valid_d = 1'b1;
                    state_d       = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (sel_valid) begin
                    tx_data_d = sel_data;
                    lock_d    = ~sel_last;
                    state_d   = START;
                end else if (tmo_hit) begin
                    lock_d        = 1'b0;
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end else begin
                    tmo_d = sat_inc(tmo_q);
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_hit) begin
                    lock_d        = 1'b0;
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end else begin
                    tmo_d = sat_inc(tmo_q);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_done) begin
                    gap_d = '0;
                    tmo_d = '0;
                    if (lock_q && en) begin
                        state_d = LOAD;
                    end else begin
                        lock_d        = 1'b0;
                        grant_valid_d = 1'b0;
                        state_d       = (en && (|req_valid)) ? ARB : IDLE;
                    end
                end else if (boud_in) begin
                    gap_d = sat_inc(gap_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational handshake outputs decoded from the current state
    always_comb begin
        req_ready = '0;
        tx_start  = 1'b0;
        tx_err    = 1'b0;
        if (state_q == LOAD && sel_valid) req_ready = N'(1) << grant_id_q;
        if (state_q == START) tx_start = 1'b1;
        if (((state_q == LOAD) && !sel_valid) || ((state_q == WAIT_BUSY) && !tx_busy))
            tx_err = tmo_hit;
    end

    assign tx_data     = tx_data_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench with packet-level round-robin model
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int GAP = 16;
    localparam int TMO = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            boud_in = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [8*N-1:0]  req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy = 1'b0;
    logic            grant_valid;
    logic [IW-1:0]   grant_id;
    logic            tx_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N(N), .GAP_TICKS(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .en(en), .boud_in(boud_in),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_valid(grant_valid), .grant_id(grant_id), .tx_err(tx_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Requester byte queues {last, data} and the expected {id, data} byte order
    logic [8:0]      rq [N][$];
    logic [IW+7:0]   exp_q [$];
    int              ptr_m = N - 1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0] rdy_cap = '0;
    logic         start_cap = 1'b0;
    int n_ready = 0, n_start = 0, n_err = 0;
    int rdy_cyc = 0, start_cyc = 0, err_cyc = 0;
    logic busy_prev = 1'b0;
    logic [7:0] held_data = '0;
    bit seq_chk_en = 1'b1;
    bit gap_on = 1'b0;
    int gap_cnt = 0;
    bit busy_mute = 1'b0;
    int busy_dly = 4, busy_len = 10;
    int tx_ph = 0, tx_cnt = 0;

    // Reference: whole packets handed out round-robin among non-empty requester queues
    task automatic plan();
        logic [8:0] cp [N][$];
        logic [8:0] b;
        int w;
        bit done;
        for (int i = 0; i < N; i++) cp[i] = rq[i];
        w = 0;
        while (w >= 0) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && cp[(ptr_m + k) % N].size() > 0) w = (ptr_m + k) % N;
            if (w >= 0) begin
                ptr_m = w;
                done = 1'b0;
                while (!done && cp[w].size() > 0) begin
                    b = cp[w].pop_front();
                    exp_q.push_back({IW'(w), b[7:0]});
                    done = b[8];
                end
            end
        end
    endtask

    // Monitor: sample everything mid-cycle
    always @(negedge clk) begin
        logic [31:0] e;
        rdy_cap   = req_ready;
        start_cap = tx_start;
        if (!rst) begin
            if (req_ready != '0) begin
                n_ready++;
                rdy_cyc = cyc;
                check_val("ready_onehot", 32'($onehot(req_ready)), 1);
                check_val("ready_is_grant", 32'(req_ready), 32'(N'(1) << grant_id));
                check_val("ready_on_valid", 32'(|(req_ready & req_valid)), 1);
                check_val("ready_granted", 32'(grant_valid), 1);
            end
            if (tx_start) begin
                n_start++;
                start_cyc = cyc;
                held_data = tx_data;
                check_val("start_after_ready", cyc - rdy_cyc, 1);
                e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
                check_val("byte_order", 32'({grant_id, tx_data}), e);
            end
            if (seq_chk_en && busy_prev && !tx_busy) begin
                check_val("data_held", 32'(tx_data), 32'(held_data));
                gap_on  = 1'b1;
                gap_cnt = 0;
            end else if (gap_on) begin
                if (req_ready != '0 || !grant_valid) begin
                    gap_on = 1'b0;
                    check_val("gap_ticks", gap_cnt, GAP);
                end else if (boud_in) begin
                    gap_cnt++;
                end
            end
            if (!seq_chk_en) gap_on = 1'b0;
            if (tx_err) begin
                n_err++;
                err_cyc = cyc;
            end
        end else begin
            gap_on = 1'b0;
        end
        busy_prev = tx_busy;
    end

    // Drivers: requesters present their queue heads, TX core model answers tx_start
    initial begin
        forever begin
            @(posedge clk);
            #1;
            boud_in = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++) begin
                if (rdy_cap[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req_valid[i] = (rq[i].size() > 0);
                req_last[i]  = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
                req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            end
            if (rst) begin
                tx_busy = 1'b0;
                tx_ph   = 0;
            end else if (start_cap && !busy_mute) begin
                tx_ph  = 1;
                tx_cnt = busy_dly;
            end else if (tx_ph == 1) begin
                if (tx_cnt <= 1) begin tx_busy = 1'b1; tx_ph = 2; tx_cnt = busy_len; end
                else tx_cnt--;
            end else if (tx_ph == 2) begin
                if (tx_cnt <= 1) begin tx_busy = 1'b0; tx_ph = 0; end
                else tx_cnt--;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic run_until_idle(input string tag);
        int budget;
        budget = 6000;
        while ((exp_q.size() > 0 || grant_valid) && budget > 0) begin
            tick(1);
            budget--;
        end
        check_val({tag, "_in_time"}, 32'(budget > 0), 1);
        check_val({tag, "_all_bytes"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, 32'(req_ready), 0);
        check_val({tag, "_start"}, 32'(tx_start), 0);
        check_val({tag, "_data"}, 32'(tx_data), 0);
        check_val({tag, "_gv"}, 32'(grant_valid), 0);
        check_val({tag, "_gid"}, 32'(grant_id), 0);
        check_val({tag, "_err"}, 32'(tx_err), 0);
    endtask

    initial begin
        int r0, s0, e0, budget;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        en  = 1'b1;
        tick(2);

        // Single byte from requester 0
        busy_dly = 10; busy_len = 10;
        r0 = n_ready; s0 = n_start;
        rq[0].push_back({1'b1, 8'hA5});
        plan();
        run_until_idle("single");
        check_val("single_ready_cnt", n_ready - r0, 1);
        check_val("single_start_cnt", n_start - s0, 1);

        // Round robin: every requester has single-byte packets, requester 0 two of them
        busy_dly = 3; busy_len = 6;
        r0 = n_ready;
        rq[0].push_back({1'b1, 8'h10}); rq[0].push_back({1'b1, 8'h11});
        rq[1].push_back({1'b1, 8'h20});
        rq[2].push_back({1'b1, 8'h30});
        rq[3].push_back({1'b1, 8'h40});
        plan();
        run_until_idle("rr");
        check_val("rr_ready_cnt", n_ready - r0, 5);

        // Packet lock: three bytes from 1 while 2 waits
        rq[1].push_back({1'b0, 8'h51}); rq[1].push_back({1'b0, 8'h52}); rq[1].push_back({1'b1, 8'h53});
        rq[2].push_back({1'b1, 8'h61});
        plan();
        run_until_idle("lock");

        // Disabled arbiter accepts nothing
        en = 1'b0;
        r0 = n_ready;
        rq[3].push_back({1'b1, 8'h77});
        tick(30);
        check_val("en_off_no_ready", n_ready - r0, 0);
        check_val("en_off_no_grant", 32'(grant_valid), 0);
        plan();
        en = 1'b1;
        run_until_idle("en_on");

        // Randomized packet mixes
        for (int r = 0; r < 4; r++) begin
            busy_dly = $urandom_range(1, 8);
            busy_len = $urandom_range(2, 12);
            for (int i = 0; i < N; i++) begin
                int np, nb;
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) begin
                    nb = $urandom_range(1, 3);
                    for (int b = 0; b < nb; b++)
                        rq[i].push_back({(b == nb - 1), 8'($urandom)});
                end
            end
            plan();
            run_until_idle("rand");
        end

        // Busy never rises: timeout TMO cycles after tx_start, then re-arbitration
        busy_mute = 1'b1;
        e0 = n_err;
        rq[2].push_back({1'b1, 8'h9C});
        plan();
        run_until_idle("busy_tmo");
        check_val("busy_tmo_err_cnt", n_err - e0, 1);
        check_val("busy_tmo_latency", err_cyc - start_cyc, TMO);
        check_val("busy_tmo_gv", 32'(grant_valid), 0);
        busy_mute = 1'b0;
        busy_dly = 2; busy_len = 5;
        rq[1].push_back({1'b1, 8'hB1});
        rq[3].push_back({1'b1, 8'hB3});
        plan();
        run_until_idle("after_tmo");

        // Lock starvation: requester 0 leaves a packet open
        rst = 1'b1; tick(2); rst = 1'b0;
        ptr_m = N - 1;
        seq_chk_en = 1'b0;
        e0 = n_err;
        rq[0].push_back({1'b0, 8'hC0});
        rq[3].push_back({1'b1, 8'hC3});
        plan();
        run_until_idle("starve");
        check_val("starve_err_cnt", n_err - e0, 1);

        // Reset while the TX core is mid-frame
        busy_dly = 2; busy_len = 60;
        rq[1].push_back({1'b1, 8'hD1});
        plan();
        budget = 200;
        while (!tx_busy && budget > 0) begin tick(1); budget--; end
        check_val("midrst_busy_seen", 32'(tx_busy), 1);
        tick(3);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("midrst");
        rst = 1'b0;
        ptr_m = N - 1;
        busy_len = 6;
        tick(3);
        seq_chk_en = 1'b1;
        rq[2].push_back({1'b1, 8'hE2});
        rq[0].push_back({1'b1, 8'hE0});
        plan();
        run_until_idle("post_rst");

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
